// File: rtl/sao_stat_scan_ctrl.sv
// SAO statistics scan controller: walks the clipped 2x2 block raster of one CTU for Y, Cb, Cr,
// strobes the accumulators and hands each finished component to the decision stage.
module sao_stat_scan_ctrl #(
   parameter int blk_22_X_len   = 6,
   parameter int blk_22_Y_len   = 6,
   parameter int pic_width_len  = 13,
   parameter int pic_height_len = 13,
   parameter int cut_x_len      = 9,
   parameter int cut_y_len      = 9,
   parameter int PIPE_DEPTH     = 2
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic                      start,
   input  logic [cut_x_len-1:0]      ctu_x,
   input  logic [cut_y_len-1:0]      ctu_y,
   input  logic [2:0]                ctb_size_log2,
   input  logic [pic_width_len-1:0]  pic_width,
   input  logic [pic_height_len-1:0] pic_height,
   input  logic                      stall_i,
   input  logic                      deci_ready,
   output logic [blk_22_X_len-1:0]   X,
   output logic [blk_22_Y_len-1:0]   Y,
   output logic [1:0]                cIdx,
   output logic [4:0]                X_len,
   output logic [4:0]                Y_len,
   output logic                      not_end,
   output logic                      isToRefresh,
   output logic                      end_of_luma_st,
   output logic                      end_of_chroma_st,
   output logic                      able_to_pass,
   output logic                      wait_forPre,
   output logic                      busy
);

   localparam int DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REFRESH,
      ST_SCAN,
      ST_DRAIN,
      ST_HANDOFF
   } state_t;

   state_t                    state;
   logic [DRAIN_W-1:0]        drain_cnt;
   logic [cut_x_len-1:0]      ctu_x_reg;
   logic [cut_y_len-1:0]      ctu_y_reg;
   logic [pic_width_len-1:0]  pic_w_reg;
   logic [pic_height_len-1:0] pic_h_reg;
   logic [2:0]                log2_reg;

   logic [2:0] start_log2;
   logic [4:0] start_x_len, start_y_len;
   logic [4:0] chroma_x_len, chroma_y_len;
   logic       at_row_end, at_last_blk;

   function automatic logic [2:0] clamp_log2(input logic [2:0] l2);
      if (l2 < 3'd4)
         return 3'd4;
      else if (l2 > 3'd6)
         return 3'd6;
      else
         return l2;
   endfunction

   // Last block index along one axis of the CTU after clipping against the picture edge.
   // The clipped extent is floored at 8 luma samples so a CTU beyond the edge cannot underflow.
   function automatic logic [4:0] last_idx(input logic [15:0] ctu_idx, input logic [15:0] pic_dim,
                                           input logic [2:0] l2, input logic chroma);
      logic [31:0] off, rem, size, wc;
      off  = 32'(ctu_idx) << l2;
      size = 32'd1 << l2;
      rem  = (32'(pic_dim) > off) ? (32'(pic_dim) - off) : 32'd0;
      wc   = (rem < size) ? rem : size;
      if (wc < 32'd8)
         wc = 32'd8;
      if (chroma)
         wc = wc >> 1;
      return 5'((wc >> 1) - 32'd1);
   endfunction

   always_comb begin
      start_log2   = clamp_log2(ctb_size_log2);
      start_x_len  = last_idx(16'(ctu_x), 16'(pic_width), start_log2, 1'b0);
      start_y_len  = last_idx(16'(ctu_y), 16'(pic_height), start_log2, 1'b0);
      chroma_x_len = last_idx(16'(ctu_x_reg), 16'(pic_w_reg), log2_reg, 1'b1);
      chroma_y_len = last_idx(16'(ctu_y_reg), 16'(pic_h_reg), log2_reg, 1'b1);
      at_row_end   = (X == blk_22_X_len'(X_len));
      at_last_blk  = at_row_end && (Y == blk_22_Y_len'(Y_len));
   end

   // not_end is the registered image of !stall_i; the raster advances only past a block that
   // was actually presented (not_end high), so stalled cycles hold X/Y.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state            <= ST_IDLE;
         drain_cnt        <= '0;
         ctu_x_reg        <= '0;
         ctu_y_reg        <= '0;
         pic_w_reg        <= '0;
         pic_h_reg        <= '0;
         log2_reg         <= 3'd4;
         X                <= '0;
         Y                <= '0;
         cIdx             <= 2'd0;
         X_len            <= 5'd0;
         Y_len            <= 5'd0;
         not_end          <= 1'b0;
         isToRefresh      <= 1'b0;
         end_of_luma_st   <= 1'b0;
         end_of_chroma_st <= 1'b0;
         able_to_pass     <= 1'b0;
         wait_forPre      <= 1'b0;
         busy             <= 1'b0;
      end else begin
         isToRefresh      <= 1'b0;
         end_of_luma_st   <= 1'b0;
         end_of_chroma_st <= 1'b0;
         able_to_pass     <= 1'b0;
         case (state)
            ST_IDLE: begin
               wait_forPre <= 1'b0;
               not_end     <= 1'b0;
               if (start) begin
                  ctu_x_reg   <= ctu_x;
                  ctu_y_reg   <= ctu_y;
                  pic_w_reg   <= pic_width;
                  pic_h_reg   <= pic_height;
                  log2_reg    <= start_log2;
                  X_len       <= start_x_len;
                  Y_len       <= start_y_len;
                  X           <= '0;
                  Y           <= '0;
                  cIdx        <= 2'd0;
                  isToRefresh <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ST_REFRESH;
               end
            end
            ST_REFRESH: begin
               not_end <= !stall_i;
               state   <= ST_SCAN;
            end
            ST_SCAN: begin
               if (not_end && at_last_blk) begin
                  not_end   <= 1'b0;
                  drain_cnt <= '0;
                  state     <= ST_DRAIN;
               end else begin
                  not_end <= !stall_i;
                  if (not_end) begin
                     if (at_row_end) begin
                        X <= '0;
                        Y <= Y + 1'b1;
                     end else begin
                        X <= X + 1'b1;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DRAIN_W'(PIPE_DEPTH - 1))
                  state <= ST_HANDOFF;
               else
                  drain_cnt <= drain_cnt + 1'b1;
            end
            ST_HANDOFF: begin
               if (deci_ready) begin
                  able_to_pass <= 1'b1;
                  wait_forPre  <= 1'b0;
                  X            <= '0;
                  Y            <= '0;
                  if (cIdx == 2'd0)
                     end_of_luma_st <= 1'b1;
                  if (cIdx == 2'd2) begin
                     end_of_chroma_st <= 1'b1;
                     cIdx             <= 2'd0;
                     busy             <= 1'b0;
                     state            <= ST_IDLE;
                  end else begin
                     cIdx        <= cIdx + 2'd1;
                     X_len       <= chroma_x_len;
                     Y_len       <= chroma_y_len;
                     isToRefresh <= 1'b1;
                     state       <= ST_REFRESH;
                  end
               end else begin
                  wait_forPre <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   a_pulse_with_pass: assert property (@(posedge clk) disable iff (!arst_n)
      (end_of_luma_st || end_of_chroma_st) |-> able_to_pass);
   a_valid_in_ctu: assert property (@(posedge clk) disable iff (!arst_n)
      not_end |-> (busy && (X <= blk_22_X_len'(X_len)) && (Y <= blk_22_Y_len'(Y_len))));

endmodule

// File: tb/tb_sao_stat_scan_ctrl.sv
// Directed bench for sao_stat_scan_ctrl: table of CTU geometries run end to end, plus stall,
// handoff back-pressure, ignored-start and mid-CTU reset sequences.
module tb_sao_stat_scan_ctrl;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        start = 1'b0;
   logic [8:0]  ctu_x = '0;
   logic [8:0]  ctu_y = '0;
   logic [2:0]  ctb_size_log2 = 3'd6;
   logic [12:0] pic_width = '0;
   logic [12:0] pic_height = '0;
   logic        stall_i = 1'b0;
   logic        deci_ready = 1'b1;
   logic [5:0]  X, Y;
   logic [1:0]  cIdx;
   logic [4:0]  X_len, Y_len;
   logic        not_end, isToRefresh, end_of_luma_st, end_of_chroma_st;
   logic        able_to_pass, wait_forPre, busy;

   sao_stat_scan_ctrl dut (
      .clk(clk), .arst_n(arst_n), .start(start), .ctu_x(ctu_x), .ctu_y(ctu_y),
      .ctb_size_log2(ctb_size_log2), .pic_width(pic_width), .pic_height(pic_height),
      .stall_i(stall_i), .deci_ready(deci_ready), .X(X), .Y(Y), .cIdx(cIdx),
      .X_len(X_len), .Y_len(Y_len), .not_end(not_end), .isToRefresh(isToRefresh),
      .end_of_luma_st(end_of_luma_st), .end_of_chroma_st(end_of_chroma_st),
      .able_to_pass(able_to_pass), .wait_forPre(wait_forPre), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cx, cy, l2, pw, ph;
      int lx, ly, chx, chy;
      int lblk, cblk, total;
   } vec_t;

   vec_t vecs[6];
   int   errors = 0;
   int   checks = 0;

   int m_xlen[3], m_ylen[3], m_blk[3];
   int raster_err, hold_err, busy_cyc, eol_cnt, eoc_cnt, atp_cnt, wait_cnt;
   int atp_cyc, ready_rise_cyc;
   bit timed_out;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_ctu(input vec_t v, input bit stall_mode, input int ready_hold,
                          input bit poke_start);
      int ex, ey, px, py, cyc;
      bit pne, done, poked;
      for (int i = 0; i < 3; i++) begin
         m_xlen[i] = -1; m_ylen[i] = -1; m_blk[i] = 0;
      end
      raster_err = 0; hold_err = 0; busy_cyc = 0; eol_cnt = 0; eoc_cnt = 0;
      atp_cnt = 0; wait_cnt = 0; atp_cyc = -1; ready_rise_cyc = -1;
      ex = 0; ey = 0; px = 0; py = 0; pne = 1'b0; done = 1'b0; poked = 1'b0; cyc = 0;
      @(negedge clk);
      ctu_x = 9'(v.cx); ctu_y = 9'(v.cy); ctb_size_log2 = 3'(v.l2);
      pic_width = 13'(v.pw); pic_height = 13'(v.ph);
      stall_i = 1'b0; deci_ready = (ready_hold == 0); start = 1'b1;
      while (!done && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (busy) busy_cyc++;
         if (isToRefresh) begin
            m_xlen[cIdx] = int'(X_len); m_ylen[cIdx] = int'(Y_len); ex = 0; ey = 0;
         end else if (busy && !pne && (int'(X) != px || int'(Y) != py)) begin
            hold_err++;
         end
         if (not_end) begin
            m_blk[cIdx]++;
            if (int'(X) != ex || int'(Y) != ey) raster_err++;
            if (ex == m_xlen[cIdx]) begin ex = 0; ey++; end
            else ex++;
         end
         if (wait_forPre) wait_cnt++;
         if (end_of_luma_st) eol_cnt++;
         if (end_of_chroma_st) eoc_cnt++;
         if (able_to_pass) begin
            atp_cnt++;
            if (atp_cnt == 1) atp_cyc = cyc;
         end
         px = int'(X); py = int'(Y); pne = not_end;
         if (eoc_cnt > 0 && !busy) done = 1'b1;
         stall_i = stall_mode ? ~stall_i : 1'b0;
         if (ready_hold > 0) begin
            if (!deci_ready && (atp_cnt > 0 || wait_cnt >= ready_hold)) ready_rise_cyc = cyc;
            deci_ready = (atp_cnt > 0) || (wait_cnt >= ready_hold);
         end
         if (poke_start && !poked && m_blk[0] == 100) begin
            start = 1'b1; ctu_x = 9'd0; ctb_size_log2 = 3'd4; pic_width = 13'd16; poked = 1'b1;
         end
      end
      stall_i = 1'b0; deci_ready = 1'b1;
      timed_out = !done;
      $display("ctu (%0d,%0d) log2=%0d pic=%0dx%0d: lens Y=%0d/%0d C=%0d/%0d blocks=%0d/%0d/%0d cycles=%0d",
               v.cx, v.cy, v.l2, v.pw, v.ph, m_xlen[0], m_ylen[0], m_xlen[1], m_ylen[1],
               m_blk[0], m_blk[1], m_blk[2], busy_cyc);
   endtask

   task automatic check_run(input vec_t v, input bit with_total);
      check("timeout", int'(timed_out), 0);
      check("luma_x_len", m_xlen[0], v.lx);
      check("luma_y_len", m_ylen[0], v.ly);
      for (int c = 1; c < 3; c++) begin
         check("chroma_x_len", m_xlen[c], v.chx);
         check("chroma_y_len", m_ylen[c], v.chy);
         check("chroma_blocks", m_blk[c], v.cblk);
      end
      check("luma_blocks", m_blk[0], v.lblk);
      check("raster_order", raster_err, 0);
      check("xy_hold", hold_err, 0);
      check("end_of_luma_cnt", eol_cnt, 1);
      check("end_of_chroma_cnt", eoc_cnt, 1);
      check("able_to_pass_cnt", atp_cnt, 3);
      if (with_total) check("ctu_cycles", busy_cyc, v.total);
   endtask

   function automatic int out_word();
      return int'({X, Y, cIdx, X_len, Y_len, not_end, isToRefresh, end_of_luma_st,
                   end_of_chroma_st, able_to_pass, wait_forPre, busy});
   endfunction

   initial begin
      int cnt, guard;
      // total = sum over components of 1 refresh + blocks + 2 drain + 1 handoff
      vecs[0] = '{0, 0, 6, 1920, 1080, 31, 31, 15, 15, 1024, 256, 1548};
      vecs[1] = '{29, 16, 6, 1920, 1080, 31, 27, 15, 13, 896, 224, 1356};
      vecs[2] = '{0, 0, 4, 1920, 1080, 7, 7, 3, 3, 64, 16, 108};
      vecs[3] = '{3, 2, 2, 64, 40, 7, 3, 3, 1, 32, 8, 60};
      vecs[4] = '{1, 1, 7, 96, 72, 15, 3, 7, 1, 64, 16, 108};
      vecs[5] = '{2, 0, 5, 72, 32, 3, 15, 1, 7, 64, 16, 108};

      repeat (3) @(negedge clk);
      check("reset_outputs", out_word(), 0);
      arst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_ctu(vecs[i], 1'b0, 0, 1'b0);
         check_run(vecs[i], 1'b1);
      end

      // stall toggling: same block count and raster, X/Y frozen on stalled cycles
      run_ctu(vecs[0], 1'b1, 0, 1'b0);
      check_run(vecs[0], 1'b0);

      // decision stage back-pressure on the luma handoff
      run_ctu(vecs[2], 1'b0, 10, 1'b0);
      check_run(vecs[2], 1'b0);
      check("wait_forPre_cycles", wait_cnt, 10);
      check("able_to_pass_latency", atp_cyc - ready_rise_cyc, 1);
      check("ctu_cycles_backpressure", busy_cyc, vecs[2].total + 10);

      // start during SCAN is ignored; next CTU started from IDLE right after
      run_ctu(vecs[1], 1'b0, 0, 1'b1);
      check_run(vecs[1], 1'b1);
      run_ctu(vecs[3], 1'b0, 0, 1'b0);
      check_run(vecs[3], 1'b1);

      // asynchronous reset in the middle of the Cb scan
      @(negedge clk);
      ctu_x = 9'd0; ctu_y = 9'd0; ctb_size_log2 = 3'd6;
      pic_width = 13'd1920; pic_height = 13'd1080; start = 1'b1;
      cnt = 0; guard = 0;
      while (cnt < 50 && guard < 3000) begin
         @(negedge clk);
         start = 1'b0;
         guard++;
         if (not_end && cIdx == 2'd1) cnt++;
      end
      check("reach_cb_scan", cnt, 50);
      #2 arst_n = 1'b0;
      #1 check("mid_reset_outputs", out_word(), 0);
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_after_reset", int'({busy, not_end, isToRefresh}), 0);
      $display("reset applied during Cb scan after %0d Cb blocks", cnt);
      run_ctu(vecs[0], 1'b0, 0, 1'b0);
      check_run(vecs[0], 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
